// File: rtl/mul_tree_bf16_param.sv
// Parameterised bf16 product tree: N_IN masked lanes reduced over k levels, one result group per 2^k lanes.
// Latency k*(MUL_LAT+1); in_ready drops only while a different mode is still in flight.

module bf16_mul #(
  parameter int LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_vld,
  input  logic [31:0] in_dat,
  output logic        out_vld,
  output logic [15:0] out_dat
);

  logic        sa, sb;
  logic [7:0]  ea, eb;
  logic [6:0]  fa, fb;
  logic [15:0] prod;
  logic        nrm, grd, stk;
  logic [6:0]  m7;
  logic [7:0]  m8;
  logic [9:0]  e_sum;
  logic [15:0] res;

  logic [LAT-1:0] v_q, v_d;
  logic [15:0]    p_q [LAT];
  logic [15:0]    p_d [LAT];

  assign sa = in_dat[31];
  assign ea = in_dat[30:23];
  assign fa = in_dat[22:16];
  assign sb = in_dat[15];
  assign eb = in_dat[14:7];
  assign fb = in_dat[6:0];

  // Round to nearest even on the 16-bit significand product; subnormal operands count as zero.
  always_comb begin
    prod  = 16'({1'b1, fa}) * 16'({1'b1, fb});
    nrm   = prod[15];
    m7    = nrm ? prod[14:8] : prod[13:7];
    grd   = nrm ? prod[7] : prod[6];
    stk   = nrm ? |prod[6:0] : |prod[5:0];
    m8    = {1'b0, m7} + {7'b0, grd & (stk | m7[0])};
    e_sum = {2'b0, ea} + {2'b0, eb} + {9'b0, nrm} + {9'b0, m8[7]};
    res   = {sa ^ sb, e_sum[7:0] - 8'd127, m8[6:0]};
    if ((ea == 8'hFF && fa != 7'h0) || (eb == 8'hFF && fb != 7'h0) ||
        (ea == 8'hFF && eb == 8'h00) || (eb == 8'hFF && ea == 8'h00)) begin
      res = 16'h7FC0;
    end else if (ea == 8'hFF || eb == 8'hFF) begin
      res = {sa ^ sb, 8'hFF, 7'h0};
    end else if (ea == 8'h00 || eb == 8'h00) begin
      res = {sa ^ sb, 15'h0};
    end else if (e_sum >= 10'd382) begin
      res = {sa ^ sb, 8'hFF, 7'h0};
    end else if (e_sum <= 10'd127) begin
      res = {sa ^ sb, 15'h0};
    end
  end

  always_comb begin
    v_d    = v_q;
    p_d    = p_q;
    v_d[0] = in_vld;
    p_d[0] = res;
    for (int i = 1; i < LAT; i++) begin
      v_d[i] = v_q[i-1];
      p_d[i] = p_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < LAT; i++) p_q[i] <= 16'h0;
    end else begin
      v_q <= v_d;
      p_q <= p_d;
    end
  end

  assign out_vld = v_q[LAT-1];
  assign out_dat = p_q[LAT-1];

endmodule

module mul_tree_bf16_param #(
  parameter int N_IN    = 8,
  parameter int MUL_LAT = 3,
  parameter int LEVELS  = $clog2(N_IN)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*16-1:0]         in_data,
  input  logic [N_IN-1:0]            in_mask,
  input  logic [$clog2(LEVELS):0]    in_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [(N_IN/2)*16-1:0]     out_data,
  output logic                       out_valid,
  output logic [$clog2(LEVELS):0]    out_mode,
  output logic                       err_mode,
  output logic                       busy
);

  localparam int MW   = $clog2(LEVELS) + 1;
  localparam int L    = MUL_LAT + 1;
  localparam int PIPE = LEVELS * L;
  localparam int CW   = $clog2(PIPE + 1);
  localparam int NO   = N_IN / 2;

  logic [15:0]   lvl_dat [LEVELS+1][N_IN];
  logic [LEVELS:0] lvl_stb;

  logic          legal, acc;
  logic [MW-1:0] eff_mode;

  logic [PIPE-1:0] vld_q, vld_d;
  logic [MW-1:0]   tag_q [PIPE];
  logic [MW-1:0]   tag_d [PIPE];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [MW-1:0]   cur_mode_q, cur_mode_d;
  logic [NO*16-1:0] out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [MW-1:0]   out_mode_q, out_mode_d;
  logic            err_q, err_d;

  assign legal    = (in_mode != '0) && (in_mode <= MW'(LEVELS));
  assign eff_mode = legal ? in_mode : MW'(1);
  assign busy     = (cnt_q != '0) | out_valid_q;
  assign in_ready = !rst && (!busy || (eff_mode == cur_mode_q));
  assign acc      = in_valid & in_ready;

  assign lvl_stb[0] = acc;
  for (genvar i = 0; i < N_IN; i++) begin : g_in
    assign lvl_dat[0][i] = in_mask[i] ? in_data[i*16 +: 16] : 16'h3F80;
  end

  for (genvar j = 1; j <= LEVELS; j++) begin : g_lvl
    localparam int NM = N_IN >> j;
    logic [15:0]   opr_q [2*NM];
    logic [15:0]   opr_d [2*NM];
    logic          stb_q, stb_d;
    logic [NM-1:0] mvld;

    always_comb begin
      stb_d = lvl_stb[j-1];
      opr_d = opr_q;
      if (lvl_stb[j-1]) begin
        for (int i = 0; i < 2*NM; i++) opr_d[i] = lvl_dat[j-1][i];
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        stb_q <= 1'b0;
        for (int i = 0; i < 2*NM; i++) opr_q[i] <= 16'h0;
      end else begin
        stb_q <= stb_d;
        opr_q <= opr_d;
      end
    end

    for (genvar m = 0; m < NM; m++) begin : g_mul
      bf16_mul #(.LAT(MUL_LAT)) u_mul (
        .clk     (clk),
        .rst     (rst),
        .in_vld  (stb_q),
        .in_dat  ({opr_q[2*m], opr_q[2*m+1]}),
        .out_vld (mvld[m]),
        .out_dat (lvl_dat[j][m])
      );
    end
    for (genvar m = NM; m < N_IN; m++) begin : g_pad
      assign lvl_dat[j][m] = 16'h0;
    end

    // Strobe only steers the next level's operand capture, never the result.
    assign lvl_stb[j] = &mvld;
  end

  always_comb begin
    vld_d      = {vld_q[PIPE-2:0], acc};
    tag_d      = tag_q;
    tag_d[0]   = eff_mode;
    for (int i = 1; i < PIPE; i++) tag_d[i] = tag_q[i-1];
    cur_mode_d = acc ? eff_mode : cur_mode_q;
    err_d      = acc & ~legal;
    out_valid_d = 1'b0;
    out_mode_d  = out_mode_q;
    out_data_d  = out_data_q;
    // A transaction of mode k retires when it reaches tag stage k*L-1.
    for (int k = 1; k <= LEVELS; k++) begin
      if (vld_q[k*L-1] && tag_q[k*L-1] == MW'(k)) begin
        out_valid_d = 1'b1;
        out_mode_d  = MW'(k);
        for (int g = 0; g < NO; g++) begin
          out_data_d[g*16 +: 16] = (g < (N_IN >> k)) ? lvl_dat[k][g] : 16'h0;
        end
      end
    end
    cnt_d = cnt_q + CW'(acc) - CW'(out_valid_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q       <= '0;
      for (int i = 0; i < PIPE; i++) tag_q[i] <= '0;
      cnt_q       <= '0;
      cur_mode_q  <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_mode_q  <= '0;
      err_q       <= 1'b0;
    end else begin
      vld_q       <= vld_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      cur_mode_q  <= cur_mode_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_mode_q  <= out_mode_d;
      err_q       <= err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_mode  = out_mode_q;
  assign err_mode  = err_q;

endmodule

// File: tb/tb_mul_tree_bf16_param.sv
// Directed bench for mul_tree_bf16_param at N_IN=8, MUL_LAT=3 (per-level latency 4).
module tb_mul_tree_bf16_param;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic [7:0]   in_mask;
  logic [2:0]   in_mode;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  out_data;
  logic         out_valid;
  logic [2:0]   out_mode;
  logic         err_mode;
  logic         busy;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] D23  = 128'h3F80_3F80_3F80_3F80_3F80_3F80_4040_4000;
  localparam logic [127:0] DALL2 = {8{16'h4000}};

  mul_tree_bf16_param #(.N_IN(8), .MUL_LAT(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_mask   (in_mask),
    .in_mode   (in_mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_mode  (out_mode),
    .err_mode  (err_mode),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one transaction and returns 1 time unit after its accepting edge.
  task automatic send(input logic [127:0] d, input logic [7:0] m, input logic [2:0] md);
    in_data  = d;
    in_mask  = m;
    in_mode  = md;
    in_valid = 1'b1;
    #1;
    for (int n = 0; n < 40 && !in_ready; n++) tick();
    chk("send_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int budget, output int lat, output int bfall, output int pulses,
                          output int errs, output logic [63:0] dat, output logic [2:0] md);
    lat = -1; bfall = -1; pulses = 0; errs = 0; dat = '0; md = '0;
    for (int n = 1; n <= budget; n++) begin
      tick();
      if (out_valid) begin
        pulses++;
        if (lat < 0) begin
          lat = n;
          dat = out_data;
          md  = out_mode;
        end
      end
      if (err_mode) errs++;
      if (!busy && bfall < 0) bfall = n;
    end
  endtask

  int lat, bfall, pulses, errs, rcnt, first_n, last_n, j;
  int acc_n, rdy_n, p3, p1;
  logic rb;
  logic [63:0] odat, d3, d1;
  logic [2:0]  omd;

  initial begin
    rst = 1'b1; in_data = '0; in_mask = '0; in_mode = '0; in_valid = 1'b0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err_mode), 64'd0);
    rst = 1'b0;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Mode 1: 2.0*3.0 in group 0, ones elsewhere.
    send(D23, 8'hFF, 3'd1);
    chk("m1_err", 64'(err_mode), 64'd0);
    chk("m1_busy", 64'(busy), 64'd1);
    wait_out(20, lat, bfall, pulses, errs, odat, omd);
    chk("m1_lat", 64'(lat), 64'd4);
    chk("m1_data", odat, 64'h3F80_3F80_3F80_40C0);
    chk("m1_mode", 64'(omd), 64'd1);
    chk("m1_pulses", 64'(pulses), 64'd1);
    chk("m1_busy_fall", 64'(bfall), 64'd5);
    chk("m1_hold", out_data, 64'h3F80_3F80_3F80_40C0);

    // Mode 3: 2^8.
    send(DALL2, 8'hFF, 3'd3);
    wait_out(25, lat, bfall, pulses, errs, odat, omd);
    chk("m3_lat", 64'(lat), 64'd12);
    chk("m3_data", odat, 64'h0000_0000_0000_4380);
    chk("m3_mode", 64'(omd), 64'd3);
    chk("m3_busy_fall", 64'(bfall), 64'd13);

    // Mode 2 with lane 3 masked to 1.0.
    send(128'h3F80_3F80_3F80_3F80_4000_4000_4000_4000, 8'hF7, 3'd2);
    wait_out(20, lat, bfall, pulses, errs, odat, omd);
    chk("m2_lat", 64'(lat), 64'd8);
    chk("m2_data", odat, 64'h0000_0000_3F80_4100);
    chk("m2_mode", 64'(omd), 64'd2);

    // Eight back-to-back mode-2 transactions, lane 0 = 2^i.
    in_mode = 3'd2; in_mask = 8'hFF; rcnt = 0;
    for (int i = 0; i < 8; i++) begin
      in_data  = {{7{16'h3F80}}, 16'h3F80 + 16'(i << 7)};
      in_valid = 1'b1;
      #1;
      if (in_ready) rcnt++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    chk("b2b_ready", 64'(rcnt), 64'd8);
    j = 0; first_n = -1; last_n = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (out_valid) begin
        chk("b2b_data", out_data, {32'h0, 16'h3F80, 16'h3F80 + 16'(j << 7)});
        if (first_n < 0) first_n = n;
        last_n = n;
        j++;
      end
    end
    chk("b2b_pulses", 64'(j), 64'd8);
    chk("b2b_first", 64'(first_n), 64'd1);
    chk("b2b_span", 64'(last_n - first_n), 64'd7);

    // Mode switch 3 -> 1 must wait for the mode-3 result to leave.
    send(DALL2, 8'hFF, 3'd3);
    in_data = D23; in_mode = 3'd1; in_valid = 1'b1;
    acc_n = -1; rdy_n = -1; p3 = -1; p1 = -1; pulses = 0; d3 = '0; d1 = '0;
    for (int n = 1; n <= 40; n++) begin
      #1;
      rb = in_ready;
      @(posedge clk);
      #1;
      if (in_valid && rb) begin
        acc_n = n;
        in_valid = 1'b0;
      end
      if (in_valid && in_ready && rdy_n < 0) rdy_n = n;
      if (out_valid) begin
        pulses++;
        if (out_mode == 3'd3) begin p3 = n; d3 = out_data; end
        else begin p1 = n; d1 = out_data; end
      end
    end
    in_valid = 1'b0;
    chk("sw_m3_at", 64'(p3), 64'd12);
    chk("sw_ready_rise", 64'(rdy_n), 64'd13);
    chk("sw_accept", 64'(acc_n), 64'd14);
    chk("sw_m1_at", 64'(p1), 64'd18);
    chk("sw_pulses", 64'(pulses), 64'd2);
    chk("sw_m3_data", d3, 64'h0000_0000_0000_4380);
    chk("sw_m1_data", d1, 64'h3F80_3F80_3F80_40C0);

    // Illegal modes 0 and 4 run as mode 1.
    send(D23, 8'hFF, 3'd0);
    chk("ill0_err", 64'(err_mode), 64'd1);
    wait_out(20, lat, bfall, pulses, errs, odat, omd);
    chk("ill0_err_once", 64'(errs), 64'd0);
    chk("ill0_lat", 64'(lat), 64'd4);
    chk("ill0_mode", 64'(omd), 64'd1);
    chk("ill0_data", odat, 64'h3F80_3F80_3F80_40C0);
    send(DALL2, 8'hFF, 3'd4);
    chk("ill4_err", 64'(err_mode), 64'd1);
    wait_out(20, lat, bfall, pulses, errs, odat, omd);
    chk("ill4_mode", 64'(omd), 64'd1);
    chk("ill4_data", odat, 64'h4080_4080_4080_4080);

    // Reset mid-flight discards the mode-3 transaction.
    send(DALL2, 8'hFF, 3'd3);
    for (int n = 0; n < 5; n++) tick();
    rst = 1'b1;
    #1;
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_out_data", out_data, 64'd0);
    chk("mr_out_mode", 64'(out_mode), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_rel_ready", 64'(in_ready), 64'd1);
    wait_out(30, lat, bfall, pulses, errs, odat, omd);
    chk("mr_no_out", 64'(pulses), 64'd0);
    chk("mr_busy_after", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mul_tree_bf16_param.md
MUL_TREE_BF16_PARAM -- requirements
Module: mul_tree_bf16_param

Interface
REQ-001 Parameter N_IN, default 8: number of bf16 input lanes; SHALL be a power of two, 4..64.
REQ-002 Parameter MUL_LAT, default 3: latency in cycles of one bf16 multiplier instance, from its input strobe to its output strobe.
REQ-003 Parameter LEVELS, default $clog2(N_IN): number of tree levels; derived, not overridden.
REQ-004 Port clk, input, 1: single clock; all state SHALL be clocked on the rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port in_data, input, N_IN*16: lane i at [i*16+:16], bf16.
REQ-007 Port in_mask, input, N_IN: lane i is used when the bit is 1; a 0 substitutes bf16 1.0 (0x3F80).
REQ-008 Port in_mode, input, $clog2(LEVELS)+1: k, giving group size 2^k, legal range 1..LEVELS.
REQ-009 Port in_valid, input, 1: transaction offered.
REQ-010 Port in_ready, output, 1: transaction accepted on an edge where in_valid & in_ready.
REQ-011 Port out_data, output, (N_IN/2)*16: group g product at [g*16+:16].
REQ-012 Port out_valid, output, 1: one-cycle pulse per accepted transaction.
REQ-013 Port out_mode, output, width of in_mode: effective k of the transaction on out_data.
REQ-014 Port err_mode, output, 1: one-cycle pulse on acceptance of an illegal in_mode.
REQ-015 Port busy, output, 1: high while any transaction is in flight.

Function
REQ-016 Tree structure SHALL be: level j (1..LEVELS) has N_IN>>j bf16 multipliers; multiplier m at level j takes outputs 2m and 2m+1 of level j-1; level 0 is the masked inputs.
REQ-017 Multipliers SHALL be instances of the team's pipelined bf16 multiplier, with operand a in [31:16] and b in [15:0].
REQ-018 Each level SHALL register its operands and strobe once before its multipliers, so per-level latency is L = MUL_LAT+1.
REQ-019 Latency: a transaction accepted at edge t with effective mode k SHALL give out_valid high on exactly one cycle, starting at edge t + k*L.
REQ-020 Mode tag: the block SHALL carry the mode per transaction in its own valid/mode shift pipeline, with async reset; in_mode changes after acceptance SHALL NOT affect in-flight results.
REQ-021 Output selection: out_data low (N_IN>>k) lanes SHALL carry level-k results; upper lanes SHALL be 0; when out_valid is 0, out_data SHALL hold its last value.
REQ-022 Illegal mode (0 or >LEVELS): the transaction SHALL be accepted with effective k=1, err_mode SHALL pulse on the cycle after acceptance, and out_mode SHALL report 1.
REQ-023 Throughput: back-to-back transactions with equal effective mode SHALL be accepted every cycle with in_ready high.
REQ-024 Mode switch: in_ready SHALL be 0 while busy and the offered effective mode differs from the mode of the in-flight transactions; it rises in the cycle after the last in-flight result leaves, so results never collide or reorder.
REQ-025 in_ready SHALL NOT depend combinationally on in_data or in_mask.
REQ-026 busy SHALL count in-flight transactions with a counter of width $clog2(LEVELS*L+1).
REQ-027 busy SHALL be high from the cycle after acceptance through the out_valid cycle of the last in-flight transaction.
REQ-028 Simultaneous accept and retire in one cycle SHALL leave the counter unchanged.
REQ-029 Multiplier strobes: only the block-tracked valid SHALL qualify a result; multiplier-internal strobes SHALL be used only to feed operands.
REQ-030 Arithmetic SHALL follow the multiplier's bf16 rounding; the tree SHALL add no rounding, normalisation or flushing.

Reset
REQ-031 When rst is high, all outputs SHALL go to 0 asynchronously: out_valid, out_data, out_mode, err_mode, busy; in_ready SHALL be 0.
REQ-032 When rst is high, the in-flight counter and the valid/mode pipeline SHALL be cleared.
REQ-033 in_ready SHALL be 1 on the first edge after rst deasserts.
REQ-034 Reset during operation SHALL discard all in-flight transactions; no out_valid SHALL appear for them after release.

Verification
REQ-035 N_IN=8, mode 1, lanes {2.0,3.0,…} (0x4000,0x4040, rest 0x3F80), mask 0xFF -> at t+4: out_valid, lane0=0x40C0, lanes1..3=0x3F80, out_mode=1.
REQ-036 N_IN=8, mode 3, all lanes 0x4000 -> at t+12: lane0=0x4380 (256.0), lanes1..3=0, busy falls after the out_valid cycle.
REQ-037 Mode 2, lanes 0..3 = 0x4000, in_mask=0xF7 -> lane0=0x4100 (8.0) at t+8; then 8 back-to-back mode-2 transactions -> 8 consecutive out_valid pulses.
REQ-038 Mode-3 transaction accepted, then mode-1 offered next cycle -> in_ready=0 until the cycle after the mode-3 out_valid; the mode-1 result follows it with no overlap.
REQ-039 in_mode=0 -> err_mode pulse at t+1, result as mode 1, out_mode=1.
REQ-040 rst pulsed 5 cycles after a mode-3 accept -> outputs 0 at once, no out_valid afterwards, in_ready=1 after release.
